// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // Device clock falls in one host-to-device frame: 8 data, parity, stop, ack.
    localparam int PS2_FRAME_FALLS = 11;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;

    // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronises one raw PS/2 line and debounces it; reports level and a fall strobe.
// Latency: 2 sync flops + FILTER_LEN equal samples, so raw edge to strobe is 2+FILTER_LEN cycles.
// Backpressure: none; free-running conditioning of an asynchronous input.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic line_raw,
    output logic level,
    output logic fall
);

    localparam int CNT_W = $clog2(FILTER_LEN + 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] run_cnt;

    // Two-flop synchroniser; idle bus level is high.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= line_raw;
            sync2 <= sync1;
        end
    end

    // Level flips only after FILTER_LEN consecutive samples disagree with it.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            level   <= 1'b1;
            fall    <= 1'b0;
            run_cnt <= '0;
        end else begin
            fall <= 1'b0;
            if (sync2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CNT_W'(FILTER_LEN - 1)) begin
                level   <= sync2;
                fall    <= level;
                run_cnt <= '0;
            end else begin
                run_cnt <= run_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 byte transmitter driving open-drain clock/data via output enables.
// Latency: INHIBIT_CYCLES+1 cycles of clock inhibit, then 11 device clock periods, then bus-idle wait.
// Backpressure: tx_ready high only in IDLE; tx_valid ignored otherwise. Option: PS2_TX_WATCHDOG_EN.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 11520,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 1920000
) (
    input  logic       clk_sys,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);

    ps2_state_t       state, state_n;
    logic [INH_W-1:0] inh_cnt, inh_cnt_n;
    logic [8:0]       shreg, shreg_n;
    logic [3:0]       bit_cnt, bit_cnt_n;
    logic             ack_q, ack_n;
    logic             data_oe_q, data_oe_n;
    logic             done_c;
    logic             error_c;

    logic             clk_level;
    logic             clk_fall;
    logic             data_level;
    // The data line only needs its level; its fall strobe has no consumer.
    logic             data_fall_unused;

    logic             wd_expired;
`ifdef PS2_TX_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]  wd_cnt, wd_cnt_n;
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT_CYCLES));
`else
    assign wd_expired = 1'b0;
`endif

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_raw (ps2_clk_i),
        .level    (clk_level),
        .fall     (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk_sys  (clk_sys),
        .reset_n  (reset_n),
        .line_raw (ps2_data_i),
        .level    (data_level),
        .fall     (data_fall_unused)
    );

    // State and datapath registers; reset releases both lines immediately.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state     <= IDLE;
            inh_cnt   <= '0;
            shreg     <= '0;
            bit_cnt   <= '0;
            ack_q     <= 1'b1;
            data_oe_q <= 1'b0;
`ifdef PS2_TX_WATCHDOG_EN
            wd_cnt    <= '0;
`endif
        end else begin
            state     <= state_n;
            inh_cnt   <= inh_cnt_n;
            shreg     <= shreg_n;
            bit_cnt   <= bit_cnt_n;
            ack_q     <= ack_n;
            data_oe_q <= data_oe_n;
`ifdef PS2_TX_WATCHDOG_EN
            wd_cnt    <= wd_cnt_n;
`endif
        end
    end

    // Next-state, frame shifting and completion pulses.
    always_comb begin
        state_n   = state;
        inh_cnt_n = inh_cnt;
        shreg_n   = shreg;
        bit_cnt_n = bit_cnt;
        ack_n     = ack_q;
        data_oe_n = data_oe_q;
        done_c    = 1'b0;
        error_c   = 1'b0;

        case (state)
            IDLE: begin
                data_oe_n = 1'b0;
                bit_cnt_n = '0;
                if (tx_valid) begin
                    shreg_n   = {odd_parity(tx_data), tx_data};
                    inh_cnt_n = '0;
                    state_n   = INHIBIT;
                end
            end
            INHIBIT: begin
                // Device clock activity here is deliberately not examined.
                if (inh_cnt == INH_W'(INHIBIT_CYCLES)) begin
                    state_n = REQ;
                end else begin
                    inh_cnt_n = inh_cnt + 1'b1;
                    // Start bit goes out during the final held-clock cycle.
                    if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
                        data_oe_n = 1'b1;
                    end
                end
            end
            REQ: begin
                if (clk_fall) begin
                    data_oe_n = ~shreg[0];
                    shreg_n   = {1'b1, shreg[8:1]};
                    bit_cnt_n = 4'd1;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == 4'(PS2_FRAME_FALLS - 2)) begin
                        // Stop bit: release data so the line floats high.
                        data_oe_n = 1'b0;
                        state_n   = ACK;
                    end else begin
                        data_oe_n = ~shreg[0];
                        shreg_n   = {1'b1, shreg[8:1]};
                    end
                end
            end
            ACK: begin
                if (clk_fall) begin
                    ack_n     = data_level;
                    bit_cnt_n = 4'(PS2_FRAME_FALLS);
                    state_n   = WAIT_IDLE;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_c  = ~ack_q;
                    error_c = ack_q;
                    state_n = IDLE;
                end
            end
            default: begin
                state_n   = IDLE;
                data_oe_n = 1'b0;
            end
        endcase

`ifdef PS2_TX_WATCHDOG_EN
        wd_cnt_n = wd_cnt;
        if (state == INHIBIT || clk_fall) begin
            wd_cnt_n = '0;
        end else if (state != IDLE && !wd_expired) begin
            wd_cnt_n = wd_cnt + 1'b1;
        end
`endif

        if (wd_expired && (state inside {REQ, SHIFT, ACK, WAIT_IDLE})) begin
            state_n   = IDLE;
            data_oe_n = 1'b0;
            bit_cnt_n = '0;
            done_c    = 1'b0;
            error_c   = 1'b1;
        end
    end

    // Handshake and pulses are masked during reset so a mid-frame reset is silent.
    assign tx_ready    = reset_n & (state == IDLE);
    assign tx_done     = reset_n & done_c;
    assign tx_error    = reset_n & error_c;
    assign ps2_clk_oe  = (state == INHIBIT);
    assign ps2_data_oe = data_oe_q;

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (LED set 0xED, reset 0xFF, ...) from the core to the attached keyboard.
- It is the opposite direction of the existing keyboard receive path.
- Runs in the clk_sys domain (96 MHz) and drives the open-drain PS/2 clock and data lines through output-enable pins.
- Reports completion or failure to the keyboard/LED controller that feeds it.

Parameters:
- INHIBIT_CYCLES, 11520: clk_sys cycles the host holds clock low before request-to-send (120 us at 96 MHz).
- FILTER_LEN, 8: consecutive equal samples required before a filtered line changes value.
- TIMEOUT_CYCLES, 1920000: watchdog limit of 20 ms; applies only with the watchdog macro.

Ports:
- clk_sys  in  1  system clock, 96 MHz.
- reset_n  in  1  synchronous, active-low reset.
- tx_data  in  8  byte to send.
- tx_valid  in  1  request; accepted on a cycle with tx_valid & tx_ready.
- tx_ready  out  1  high in IDLE only.
- tx_done  out  1  one-cycle pulse: byte sent and ACK seen.
- tx_error  out  1  one-cycle pulse: no ACK or timeout.
- ps2_clk_i  in  1  raw PS/2 clock line.
- ps2_data_i  in  1  raw PS/2 data line.
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.

Behaviour:
- Reset (reset_n=0 at a clk_sys edge) forces IDLE, and while in reset:
  - ps2_clk_oe=0, ps2_data_oe=0, tx_ready=0, tx_done=0, tx_error=0;
  - bit counter cleared;
  - filters preset to 1.
- On the first cycle after reset, tx_ready=1.
- Reset mid-transfer releases both lines on the same edge; no tx_done or tx_error pulse.
- Input conditioning:
  - both raw lines pass through a 2-flop synchronizer, then a FILTER_LEN-sample filter;
  - clk_fall is a one-cycle strobe when the filtered clock goes 1 to 0;
  - latency from raw line to strobe is 2+FILTER_LEN cycles.
- On accept: latch tx_data; compute parity = ~^tx_data (odd parity); go to INHIBIT.
- State INHIBIT:
  - ps2_clk_oe=1, ps2_data_oe=0, for exactly INHIBIT_CYCLES cycles;
  - then ps2_data_oe=1 (start bit) for one cycle with clock still held;
  - then go to REQ.
- State REQ: ps2_clk_oe=0, data held low; wait for clk_fall.
- State SHIFT: bit counter n=0..10 counts clk_fall events.
  - Each clk_fall drives the next bit onto data via ps2_data_oe = ~bit.
  - Falls 1-8 drive d0..d7, LSB first.
  - Fall 9 drives parity.
  - Fall 10 releases data (stop bit = 1).
- State ACK:
  - on fall 11, sample filtered data; 0 means ACK;
  - then go to WAIT_IDLE.
- State WAIT_IDLE:
  - wait until filtered clock and data are both 1;
  - then pulse tx_done (ACK was 0) or tx_error (ACK was 1);
  - return to IDLE, where tx_ready=1 on the next cycle.
- tx_valid is ignored while tx_ready=0; no queuing.
- tx_data is sampled only at accept.
- clk_fall arriving during INHIBIT (device activity) is ignored.
- The counter never wraps past 11.
- ps2_clk_oe is never asserted outside INHIBIT.

Optional Feature:
- Macro: PS2_TX_WATCHDOG_EN.
- With it defined:
  - a counter restarts at leaving INHIBIT and at each clk_fall;
  - if it reaches TIMEOUT_CYCLES in REQ, SHIFT, ACK or WAIT_IDLE, both lines are released, tx_error pulses once, and the block returns to IDLE.
- Without it: no counter; the block waits indefinitely; TIMEOUT_CYCLES is unused.

Decomposition:
- Package ps2_pkg:
  - state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - constant PS2_FRAME_FALLS=11;
  - command constants PS2_CMD_SET_LED=8'hED and PS2_CMD_RESET=8'hFF.
- One sub-module, ps2_line_filter: synchronizer plus FILTER_LEN filter, parameter FILTER_LEN.
  - Outputs: level, fall strobe.
  - Instanced twice, once for clock and once for data.

Test Plan:
1. Send 0xED with the device model ACKing:
   - clock held low for 11520 cycles;
   - data bits seen at the device's rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1;
   - ACK is accepted, then exactly one tx_done pulse and tx_ready=1.
2. Send 0x01 -> parity bit on the wire is 0; 0xFF -> parity 1; tx_done each time.
3. Device withholds ACK (data high at fall 11) -> tx_error pulse, no tx_done, lines released.
4. tx_valid held high with 0x55 during a 0xED transfer -> ignored; the 0x55 frame starts only after tx_ready returns.
5. reset_n low at fall 5 -> both oe outputs 0 on that edge, no pulses; a later 0xED completes normally.
6. With PS2_TX_WATCHDOG_EN and TIMEOUT_CYCLES=1000, the device never clocks -> tx_error 1000 cycles after REQ entry, IDLE.
   - Without the macro, the block is still in REQ after 10000 cycles.
